// File: rtl/rtc_access_scheduler_pkg.sv
// Shared types and constants for the RTC access scheduler.
// States, owner IDs, field offsets and default engine addresses.
package rtc_access_scheduler_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  typedef enum logic [1:0] {
    OWN_WR    = 2'd0,
    OWN_TIME  = 2'd1,
    OWN_CRONO = 2'd2
  } owner_e;

  localparam logic [1:0] OFS_SEC = 2'd0;
  localparam logic [1:0] OFS_MIN = 2'd1;
  localparam logic [1:0] OFS_HR  = 2'd2;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_TIMEOUT = 1023;

  localparam logic [7:0] DEF_TIME_BASE  = 8'h21;
  localparam logic [7:0] DEF_CRONO_BASE = 8'h41;

endpackage

// File: rtl/rtc_access_scheduler_if.sv
// Register-access engine bus: one start/done
// handshake per single-register access.
interface rtc_access_scheduler_if
  import rtc_access_scheduler_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              start;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;

  modport master (
    output start, we, addr, wdata,
    input  rdata, done
  );

  modport slave (
    input  start, we, addr, wdata,
    output rdata, done
  );
endinterface

// File: rtl/rtc_access_scheduler_arbiter.sv
// Request arbiter: write has strict priority,
// the two readers share the rest round robin.
module rtc_req_arbiter
  import rtc_access_scheduler_pkg::*;
(
  input  logic   clk,
  input  logic   Reset,
  input  logic   wr_req_i,
  input  logic   time_req_i,
  input  logic   crono_req_i,
  input  logic   grant_en_i,
  output logic   gnt_vld_o,
  output owner_e gnt_own_o
);

  // rr_q=1: crono wins a tie between the readers
  logic rr_q;
  logic pick_wr;
  logic pick_t;
  logic pick_c;

  assign pick_wr = wr_req_i;
  assign pick_t  = !wr_req_i && time_req_i &&
                   (!crono_req_i || !rr_q);
  assign pick_c  = !wr_req_i && crono_req_i &&
                   (!time_req_i || rr_q);

  assign gnt_vld_o = pick_wr | pick_t | pick_c;

  always_comb begin
    gnt_own_o = OWN_WR;
    unique case (1'b1)
      pick_wr: gnt_own_o = OWN_WR;
      pick_t:  gnt_own_o = OWN_TIME;
      pick_c:  gnt_own_o = OWN_CRONO;
      default: gnt_own_o = OWN_WR;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rr_q <= 1'b0;
    end else if (grant_en_i && (pick_t || pick_c)) begin
      rr_q <= pick_t;
    end
  end

endmodule

// File: rtl/rtc_access_scheduler.sv
// Shares the RTC register engine among time write, time read
// and crono read; each grant is a sec/min/hr burst.
module rtc_access_scheduler
  import rtc_access_scheduler_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] TIME_BASE =
    ADDR_W'(DEF_TIME_BASE),
  parameter logic [ADDR_W-1:0] CRONO_BASE =
    ADDR_W'(DEF_CRONO_BASE),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              wr_req_i,
  input  logic [DATA_W-1:0] wr_hh_i,
  input  logic [DATA_W-1:0] wr_mm_i,
  input  logic [DATA_W-1:0] wr_ss_i,
  output logic              wr_ack_o,
  input  logic              rd_time_req_i,
  input  logic              rd_crono_req_i,
  output logic              rd_time_ack_o,
  output logic              rd_crono_ack_o,
  output logic [DATA_W-1:0] time_hh_o,
  output logic [DATA_W-1:0] time_mm_o,
  output logic [DATA_W-1:0] time_ss_o,
  output logic [DATA_W-1:0] crono_hh_o,
  output logic [DATA_W-1:0] crono_mm_o,
  output logic [DATA_W-1:0] crono_ss_o,
  rtc_access_scheduler_if.master eng,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // index 0 = seconds, 1 = minutes, 2 = hours
  logic [2:0][DATA_W-1:0] wdat_q;
  logic [2:0][DATA_W-1:0] shd_q;
  logic [2:0][DATA_W-1:0] time_q;
  logic [2:0][DATA_W-1:0] crono_q;

  logic              gnt_en;
  logic              gnt_vld;
  owner_e            gnt_own;
  logic              active;
  logic              shd_we;
  logic              fin_time;
  logic              fin_crono;
  logic [ADDR_W-1:0] base;

  assign gnt_en = (state_q == S_IDLE);

  rtc_req_arbiter u_arb (
    .clk         (clk),
    .Reset       (Reset),
    .wr_req_i    (wr_req_i),
    .time_req_i  (rd_time_req_i),
    .crono_req_i (rd_crono_req_i),
    .grant_en_i  (gnt_en),
    .gnt_vld_o   (gnt_vld),
    .gnt_own_o   (gnt_own)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_own;
          idx_d   = OFS_SEC;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // done on the last allowed cycle still wins
        if (eng.done) begin
          if (idx_q == OFS_HR) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_ISSUE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign shd_we = (state_q == S_WAIT) && eng.done &&
                  (owner_q != OWN_WR);

  assign fin_time  = (state_q == S_FIN) &&
                     (owner_q == OWN_TIME);
  assign fin_crono = (state_q == S_FIN) &&
                     (owner_q == OWN_CRONO);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_WR;
      idx_q   <= '0;
      cnt_q   <= '0;
      wdat_q  <= '0;
      shd_q   <= '0;
      time_q  <= '0;
      crono_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (gnt_en && gnt_vld && gnt_own == OWN_WR) begin
        wdat_q <= {wr_hh_i, wr_mm_i, wr_ss_i};
      end
      if (err_o) begin
        shd_q <= '0;
      end else if (shd_we) begin
        shd_q[idx_q] <= eng.rdata;
      end
      if (fin_time) begin
        time_q <= shd_q;
      end
      if (fin_crono) begin
        crono_q <= shd_q;
      end
    end
  end

  assign active = (state_q == S_ISSUE) ||
                  (state_q == S_WAIT);
  assign base   = (owner_q == OWN_CRONO) ?
                  CRONO_BASE : TIME_BASE;

  assign eng.start = (state_q == S_ISSUE);
  assign eng.we    = active && (owner_q == OWN_WR);
  assign eng.addr  = active ?
                     base + ADDR_W'(idx_q) : '0;
  assign eng.wdata = eng.we ? wdat_q[idx_q] : '0;

  // FIN shows the shadow so ack and new values coincide
  assign {time_hh_o, time_mm_o, time_ss_o} =
    fin_time ? shd_q : time_q;
  assign {crono_hh_o, crono_mm_o, crono_ss_o} =
    fin_crono ? shd_q : crono_q;

  assign wr_ack_o       = (state_q == S_FIN) &&
                          (owner_q == OWN_WR);
  assign rd_time_ack_o  = fin_time;
  assign rd_crono_ack_o = fin_crono;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler: engine model plus
// a request-level reference of grants and committed values.
module tb_rtc_access_scheduler;

  localparam int TMO = 1023;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    int         cyc;
  } acc_t;

  typedef struct {
    int          kind;
    int          cyc;
    logic [23:0] tm;
    logic [23:0] cr;
  } ev_t;

  logic clk;
  logic Reset;
  logic wr_req, rd_time_req, rd_crono_req;
  logic [7:0] wr_hh, wr_mm, wr_ss;
  logic wr_ack, rd_time_ack, rd_crono_ack;
  logic [7:0] time_hh, time_mm, time_ss;
  logic [7:0] crono_hh, crono_mm, crono_ss;
  logic busy, err;

  logic resp_done, stray_done;
  logic [7:0] resp_rdata;
  bit   hang;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_w [3];
  logic [23:0] exp_time, exp_crono;
  bit rr_crono;

  acc_t acc_q[$];
  ev_t  ev_q[$];

  rtc_access_scheduler_if #(.DATA_W(8), .ADDR_W(8)) eng();

  assign eng.done  = resp_done | stray_done;
  assign eng.rdata = resp_rdata;

  rtc_access_scheduler dut (
    .clk            (clk),
    .Reset          (Reset),
    .wr_req_i       (wr_req),
    .wr_hh_i        (wr_hh),
    .wr_mm_i        (wr_mm),
    .wr_ss_i        (wr_ss),
    .wr_ack_o       (wr_ack),
    .rd_time_req_i  (rd_time_req),
    .rd_crono_req_i (rd_crono_req),
    .rd_time_ack_o  (rd_time_ack),
    .rd_crono_ack_o (rd_crono_ack),
    .time_hh_o      (time_hh),
    .time_mm_o      (time_mm),
    .time_ss_o      (time_ss),
    .crono_hh_o     (crono_hh),
    .crono_mm_o     (crono_mm),
    .crono_ss_o     (crono_ss),
    .eng            (eng),
    .busy_o         (busy),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // engine: done one cycle after start, unless hung
  bit pend;
  logic [7:0] rd;
  initial begin
    resp_done  = 1'b0;
    resp_rdata = 8'h00;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      if (!Reset && eng.start) begin
        acc_q.push_back('{eng.addr, eng.we, eng.wdata, cyc});
        if (eng.we) mem[eng.addr] = eng.wdata;
        rd   = mem[eng.addr];
        pend = !hang;
      end
      if (wr_ack || rd_time_ack || rd_crono_ack || err)
        ev_q.push_back('{
          wr_ack ? 0 : rd_time_ack ? 1 : rd_crono_ack ? 2 : 3,
          cyc,
          {time_hh, time_mm, time_ss},
          {crono_hh, crono_mm, crono_ss}});
      @(posedge clk);
      #1;
      resp_done  = pend;
      resp_rdata = pend ? rd : 8'($urandom);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // grant rule: write first, else alternate the readers
  function automatic int predict();
    int own;
    if (wr_req) own = 0;
    else if (rd_time_req && rd_crono_req)
      own = rr_crono ? 2 : 1;
    else if (rd_time_req) own = 1;
    else own = 2;
    if (own != 0) rr_crono = (own == 1);
    return own;
  endfunction

  task automatic set_wr(input logic [7:0] ss,
                        input logic [7:0] mm,
                        input logic [7:0] hh);
    wr_ss = ss; wr_mm = mm; wr_hh = hh;
    exp_w[0] = ss; exp_w[1] = mm; exp_w[2] = hh;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 3; i++) begin
      mem[8'h21 + i] = 8'($urandom);
      mem[8'h41 + i] = 8'($urandom);
    end
  endtask

  task automatic expect_burst(input string tag,
                              input bit scramble,
                              output int start0);
    int own;
    int n;
    ev_t e;
    acc_t a;
    logic [7:0] base;
    logic [23:0] got;
    own    = predict();
    base   = (own == 2) ? 8'h41 : 8'h21;
    start0 = -1;
    n      = 0;
    got    = '0;
    while (ev_q.size() == 0 && n < 40) begin
      @(negedge clk);
      #2;
      n++;
      if (scramble && n == 3) begin
        wr_ss = 8'($urandom);
        wr_mm = 8'($urandom);
        wr_hh = 8'($urandom);
      end
    end
    chk({tag, " ack_seen"}, 32'(ev_q.size() != 0), 1);
    if (ev_q.size() == 0) return;
    e = ev_q.pop_front();
    chk({tag, " owner"}, e.kind, own);
    chk({tag, " naccess"}, acc_q.size(), 3);
    if (acc_q.size() < 3) return;
    for (int i = 0; i < 3; i++) begin
      a = acc_q.pop_front();
      if (i == 0) start0 = a.cyc;
      chk({tag, " addr"}, a.addr, 32'(base) + i);
      chk({tag, " we"}, a.we, 32'(own == 0));
      chk({tag, " spacing"}, a.cyc, start0 + 2 * i);
      if (own == 0) chk({tag, " wdata"}, a.wdata, exp_w[i]);
      got[8*i +: 8] = mem[a.addr];
    end
    chk({tag, " ack_cycle"}, e.cyc, start0 + 6);
    if (own == 1) exp_time = got;
    if (own == 2) exp_crono = got;
    chk({tag, " time"}, e.tm, exp_time);
    chk({tag, " crono"}, e.cr, exp_crono);
  endtask

  int   s0, t0, n, own, prev, nt, nc;
  ev_t  e;
  acc_t a;

  initial begin
    Reset = 1'b1;
    wr_req = 0; rd_time_req = 0; rd_crono_req = 0;
    set_wr(8'h00, 8'h00, 8'h00);
    stray_done = 1'b0;
    hang = 1'b0;
    exp_time = '0; exp_crono = '0; rr_crono = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst busy", busy, 0);
    chk("rst eng", {eng.start, eng.we, eng.addr, eng.wdata}, 0);
    chk("rst acks", {wr_ack, rd_time_ack, rd_crono_ack, err}, 0);
    chk("rst time", {time_hh, time_mm, time_ss}, 0);
    chk("rst crono", {crono_hh, crono_mm, crono_ss}, 0);
    Reset = 1'b0;
    @(negedge clk);
    #2;

    // 1: time read, fixed data and latency
    mem[8'h21] = 8'h30; mem[8'h22] = 8'h15; mem[8'h23] = 8'h09;
    t0 = cyc;
    rd_time_req = 1'b1;
    expect_burst("t1", 0, s0);
    rd_time_req = 1'b0;
    chk("t1 start_lat", s0, t0 + 1);
    chk("t1 value", {time_hh, time_mm, time_ss}, 24'h091530);
    @(negedge clk);
    #2;
    chk("t1 hold", {time_hh, time_mm, time_ss}, 24'h091530);
    chk("t1 idle", busy, 0);

    // 2: write beats crono read; wr_* scrambled mid-burst
    set_wr(8'h45, 8'h59, 8'h23);
    wr_req = 1'b1;
    rd_crono_req = 1'b1;
    expect_burst("t2 wr", 1, s0);
    wr_req = 1'b0;
    expect_burst("t2 crono", 0, s0);
    rd_crono_req = 1'b0;
    @(negedge clk);
    #2;
    rd_time_req = 1'b1;
    expect_burst("t2 readback", 0, s0);
    rd_time_req = 1'b0;
    chk("t2 written", {time_hh, time_mm, time_ss}, 24'h235945);

    // 3: both readers held, six bursts alternate
    @(negedge clk);
    #2;
    rand_mem();
    rd_time_req = 1'b1;
    rd_crono_req = 1'b1;
    prev = -1; nt = 0; nc = 0;
    for (int k = 0; k < 6; k++) begin
      own = rr_crono ? 2 : 1;
      expect_burst("t3 rr", 0, s0);
      if (own == 1) nt++; else nc++;
      if (prev >= 0) chk("t3 alternate", 32'(own != prev), 1);
      prev = own;
      rand_mem();
    end
    rd_time_req = 1'b0;
    rd_crono_req = 1'b0;
    chk("t3 fairness", {nt[7:0], nc[7:0]}, 16'h0303);
    @(negedge clk);
    #2;

    // 4: engine hangs, burst aborts on timeout
    hang = 1'b1;
    rd_time_req = 1'b1;
    void'(predict());
    n = 0;
    while (ev_q.size() == 0 && n < TMO + 20) begin
      @(negedge clk);
      #2;
      n++;
      if (n == 10) chk("t4 busy", busy, 1);
    end
    rd_time_req = 1'b0;
    hang = 1'b0;
    chk("t4 ev_seen", 32'(ev_q.size() != 0), 1);
    chk("t4 naccess", acc_q.size(), 1);
    if (ev_q.size() != 0 && acc_q.size() != 0) begin
      e = ev_q.pop_front();
      a = acc_q.pop_front();
      chk("t4 kind", e.kind, 3);
      chk("t4 err_lat", e.cyc - a.cyc, TMO);
      chk("t4 time", e.tm, exp_time);
      chk("t4 crono", e.cr, exp_crono);
    end
    @(negedge clk);
    #2;
    chk("t4 idle", busy, 0);
    chk("t4 keep", {time_hh, time_mm, time_ss}, exp_time);
    rd_time_req = 1'b1;
    rd_crono_req = 1'b1;
    expect_burst("t4 next", 0, s0);
    rd_time_req = 1'b0;
    rd_crono_req = 1'b0;
    @(negedge clk);
    #2;

    // 5: reset during WAIT of the minutes access
    rand_mem();
    rd_crono_req = 1'b1;
    n = 0;
    while (acc_q.size() < 2 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("t5 reached", acc_q.size(), 2);
    @(posedge clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("t5 busy", busy, 0);
    chk("t5 start", eng.start, 0);
    chk("t5 time", {time_hh, time_mm, time_ss}, 0);
    chk("t5 crono", {crono_hh, crono_mm, crono_ss}, 0);
    rd_crono_req = 1'b0;
    exp_time = '0; exp_crono = '0; rr_crono = 1'b0;
    @(negedge clk);
    #2;
    Reset = 1'b0;
    acc_q.delete();
    ev_q.delete();
    @(negedge clk);
    #2;
    rd_time_req = 1'b1;
    expect_burst("t5 fresh", 0, s0);
    rd_time_req = 1'b0;

    // 6: stray done in IDLE
    @(negedge clk);
    #2;
    stray_done = 1'b1;
    @(negedge clk);
    #2;
    stray_done = 1'b0;
    @(negedge clk);
    #2;
    chk("t6 idle_busy", busy, 0);
    chk("t6 idle_acc", acc_q.size() + ev_q.size(), 0);

    // random request mixes; stray done in FIN on the first
    for (int k = 0; k < 8; k++) begin
      rand_mem();
      set_wr(8'($urandom), 8'($urandom), 8'($urandom));
      wr_req       = 1'($urandom_range(0, 1));
      rd_time_req  = 1'($urandom_range(0, 1));
      rd_crono_req = 1'($urandom_range(0, 1));
      if (!wr_req && !rd_crono_req) rd_time_req = 1'b1;
      expect_burst("rnd", 1, s0);
      wr_req = 1'b0;
      rd_time_req = 1'b0;
      rd_crono_req = 1'b0;
      if (k == 0) begin
        stray_done = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b0;
        @(negedge clk);
        #2;
        chk("t6 fin_busy", busy, 0);
        chk("t6 fin_acc", acc_q.size() + ev_q.size(), 0);
      end
      @(negedge clk);
      #2;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
